// File: rtl/clock_monitor.sv
// Clock monitor: measures the period and high time of an asynchronous
// divided clock against a nominal divisor, tracks lock over consecutive
// in-tolerance periods, and counts loss-of-lock events.
module clock_monitor #(
    parameter logic [27:0] EXPECTED_DIVISOR = 28'd2,
    parameter logic [27:0] TOLERANCE        = 28'd0,
    parameter int          LOCK_COUNT       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_clk_in,
    output logic [27:0] period,
    output logic [27:0] high_time,
    output logic        period_valid,
    output logic        locked,
    output logic        fault,
    output logic [7:0]  fault_count
);

    typedef enum logic [1:0] {
        SEEK,
        ACQ,
        LOCKED
    } state_t;

    localparam logic [27:0] CNT_MAX     = 28'hFFFFFFF;
    localparam logic [28:0] TIMEOUT_LIM = {EXPECTED_DIVISOR, 1'b0};
    localparam logic [3:0]  LOCK_TARGET = 4'(LOCK_COUNT);

    state_t      state;
    logic        sync1;
    logic        sync2;
    logic        sync_dly;
    logic [27:0] cycle_cnt;
    logic [27:0] high_cnt;
    logic [3:0]  good_cnt;

    logic        rise;
    logic        timeout;
    logic [27:0] abs_err;
    logic        in_tol;

    // Edge detect, timeout and tolerance classification of the running count.
    // The count at a rise equals the rise-to-rise period just completed.
    always_comb begin
        rise    = sync2 & ~sync_dly;
        timeout = ({1'b0, cycle_cnt} >= TIMEOUT_LIM);
        if (cycle_cnt >= EXPECTED_DIVISOR) begin
            abs_err = cycle_cnt - EXPECTED_DIVISOR;
        end else begin
            abs_err = EXPECTED_DIVISOR - cycle_cnt;
        end
        in_tol = (abs_err <= TOLERANCE);
    end

    // Two-flop synchronizer followed by a delay flop for rise detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            sync_dly <= 1'b0;
        end else begin
            sync1    <= div_clk_in;
            sync2    <= sync1;
            sync_dly <= sync2;
        end
    end

    // Saturating period and high-phase counters, restarted by every rise.
    // The rise cycle itself is high and is the first cycle of the new period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= 28'd0;
            high_cnt  <= 28'd0;
        end else if (rise) begin
            cycle_cnt <= 28'd1;
            high_cnt  <= 28'd1;
        end else begin
            if (cycle_cnt != CNT_MAX) begin
                cycle_cnt <= cycle_cnt + 28'd1;
            end
            if (sync2 && (high_cnt != CNT_MAX)) begin
                high_cnt <= high_cnt + 28'd1;
            end
        end
    end

    // Lock tracking FSM with registered measurement, lock and fault outputs.
    // A rise always wins over a timeout in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= SEEK;
            good_cnt     <= 4'd0;
            period       <= 28'd0;
            high_time    <= 28'd0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            fault        <= 1'b0;
            fault_count  <= 8'd0;
        end else begin
            period_valid <= 1'b0;
            fault        <= 1'b0;
            case (state)
                SEEK: begin
                    locked <= 1'b0;
                    if (rise) begin
                        state    <= ACQ;
                        good_cnt <= 4'd0;
                    end
                end
                ACQ: begin
                    if (rise) begin
                        period_valid <= 1'b1;
                        period       <= cycle_cnt;
                        high_time    <= high_cnt;
                        if (in_tol) begin
                            good_cnt <= good_cnt + 4'd1;
                            if ((good_cnt + 4'd1) == LOCK_TARGET) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            good_cnt <= 4'd0;
                        end
                    end else if (timeout) begin
                        state    <= SEEK;
                        good_cnt <= 4'd0;
                    end
                end
                LOCKED: begin
                    if (rise) begin
                        period_valid <= 1'b1;
                        period       <= cycle_cnt;
                        high_time    <= high_cnt;
                        if (!in_tol) begin
                            state    <= ACQ;
                            good_cnt <= 4'd0;
                            locked   <= 1'b0;
                            fault    <= 1'b1;
                            if (fault_count != 8'hFF) begin
                                fault_count <= fault_count + 8'd1;
                            end
                        end
                    end else if (timeout) begin
                        state    <= SEEK;
                        good_cnt <= 4'd0;
                        locked   <= 1'b0;
                        fault    <= 1'b1;
                        if (fault_count != 8'hFF) begin
                            fault_count <= fault_count + 8'd1;
                        end
                    end
                end
                default: begin
                    state    <= SEEK;
                    good_cnt <= 4'd0;
                    locked   <= 1'b0;
                end
            endcase
        end
    end

endmodule
